// File: rtl/vs_pkg.sv
// rtl/vs_pkg.sv - shared types and handshake helpers for valid/stall (VS) blocks
//
// Purpose: state encoding for the VS serializer and the two handshake
// conditions used on every valid/stall boundary in the VS family.
// Ports: none (package).

package vs_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } vs_ser_state_t;

   // A bit (or word) moves from producer to consumer when it is offered
   // and the consumer is not stalling.
   function automatic logic vs_bit_xfer(input logic i_valid, input logic i_stall);
      return i_valid & ~i_stall;
   endfunction

   // An upstream word is taken when it is offered and we are not stalling it.
   function automatic logic vs_word_accept(input logic i_valid, input logic i_stall);
      return i_valid & ~i_stall;
   endfunction

endpackage

// File: rtl/vs_serializer.sv
// rtl/vs_serializer.sv - parallel-in, serial-out converter with valid/stall handshakes
//
// Purpose: accepts a W-bit word from upstream and emits it one bit per
// downstream transfer, LSB first by default (MSB first when MSB_FIRST=1).
// A new word may be accepted in the same cycle the last bit transfers, so
// back-to-back words stream with no gap.
// Ports:
//   clk       - clock, all state changes on posedge
//   rst       - synchronous active-high reset
//   valid_us  - upstream word valid
//   data_us   - upstream word, sampled only on an accept cycle
//   stall_us  - combinational; upstream word not accepted this cycle
//   valid_ds  - serial bit present on bit_ds
//   bit_ds    - current serial bit
//   last_ds   - high with the final bit of a word
//   stall_ds  - downstream cannot take the bit this cycle

module vs_serializer
   import vs_pkg::*;
#(
   parameter int W         = 8,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         valid_us,
   input  logic [W-1:0] data_us,
   output logic         stall_us,
   output logic         valid_ds,
   output logic         bit_ds,
   output logic         last_ds,
   input  logic         stall_ds
);

   localparam int            CW       = $clog2(W);
   localparam logic [CW-1:0] LAST_IDX = CW'(W - 1);

   vs_ser_state_t r_state;
   logic [W-1:0]  r_sreg;
   logic [CW-1:0] r_cnt;

   logic w_last;
   logic w_xfer;
   logic w_accept;

   // The shift register always drains from bit 0, so MSB-first order is
   // obtained by reversing the word once at load time.
   function automatic logic [W-1:0] order_word(input logic [W-1:0] i_d);
      logic [W-1:0] v_r;
      v_r = i_d;
      if (MSB_FIRST) begin
         for (int i = 0; i < W; i++) begin
            v_r[i] = i_d[W-1-i];
         end
      end
      return v_r;
   endfunction

   // Explicit compare against W-1 so non-power-of-2 widths never wrap.
   assign w_last   = (r_state == SHIFT) && (r_cnt == LAST_IDX);
   assign valid_ds = (r_state == SHIFT);
   assign bit_ds   = r_sreg[0];          // sreg is held at zero while idle
   assign last_ds  = w_last;

   // Only the final bit's transfer frees the slot for the next word.
   assign stall_us = (r_state == SHIFT) & ~(w_last & ~stall_ds);

   assign w_xfer   = vs_bit_xfer(valid_ds, stall_ds);
   assign w_accept = vs_word_accept(valid_us, stall_us);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_sreg  <= '0;
         r_cnt   <= '0;
      end else if (r_state == IDLE) begin
         if (w_accept) begin
            r_sreg  <= order_word(data_us);
            r_cnt   <= '0;
            r_state <= SHIFT;
         end
      end else if (w_xfer) begin
         if (!w_last) begin
            r_sreg <= {1'b0, r_sreg[W-1:1]};
            r_cnt  <= r_cnt + CW'(1);
         end else if (w_accept) begin
            r_sreg <= order_word(data_us);
            r_cnt  <= '0;
         end else begin
            r_state <= IDLE;
            r_sreg  <= '0;
            r_cnt   <= '0;
         end
      end
   end

endmodule

// File: tb/tb_vs_serializer.sv
// tb/tb_vs_serializer.sv - scoreboard bench for vs_serializer

module tb_vs_serializer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // W=8 LSB-first instance
   logic       v8 = 1'b0, s8 = 1'b0;
   logic [7:0] d8 = '0;
   logic       st8, vd8, b8, l8;
   // W=8 MSB-first instance
   logic       vm = 1'b0, sm = 1'b0;
   logic [7:0] dm = '0;
   logic       stm, vdm, bm, lm;
   // W=5 LSB-first instance
   logic       v5 = 1'b0, s5 = 1'b0;
   logic [4:0] d5 = '0;
   logic       st5, vd5, b5, l5;

   vs_serializer #(.W(8), .MSB_FIRST(1'b0)) u8 (
      .clk(clk), .rst(rst), .valid_us(v8), .data_us(d8), .stall_us(st8),
      .valid_ds(vd8), .bit_ds(b8), .last_ds(l8), .stall_ds(s8));
   vs_serializer #(.W(8), .MSB_FIRST(1'b1)) um (
      .clk(clk), .rst(rst), .valid_us(vm), .data_us(dm), .stall_us(stm),
      .valid_ds(vdm), .bit_ds(bm), .last_ds(lm), .stall_ds(sm));
   vs_serializer #(.W(5), .MSB_FIRST(1'b0)) u5 (
      .clk(clk), .rst(rst), .valid_us(v5), .data_us(d5), .stall_us(st5),
      .valid_ds(vd5), .bit_ds(b5), .last_ds(l5), .stall_ds(s5));

   int total = 0;
   int bad   = 0;

   // expected {last, bit} per transfer, in emission order
   logic [1:0] q8[$];
   logic [1:0] qm[$];
   logic [1:0] q5[$];

   logic       chk_bubble = 1'b0;
   logic [7:0] shm = '0;   // downstream deserializer model, LSB first

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // seq is written in emission order: seq[n-1] is the first bit out
   task automatic push_seq(input int which, input logic [7:0] seq, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         if (which == 0)      q8.push_back({i == 0, seq[i]});
         else if (which == 1) qm.push_back({i == 0, seq[i]});
         else                 q5.push_back({i == 0, seq[i]});
      end
   endtask

   // Called just after a posedge; offers w until accepted, returns just after
   // the accepting posedge with v8 still high.
   task automatic accept8(input logic [7:0] w, input logic [7:0] seq);
      bit done;
      done = 0;
      v8 = 1'b1;
      d8 = w;
      for (int k = 0; k < 40 && !done; k++) begin
         @(negedge clk);
         if (chk_bubble) chk("bubble_valid", vd8, 1'b1);
         if (st8 === 1'b0) begin
            push_seq(0, seq, 8);
            done = 1;
         end
         @(posedge clk); #1;
      end
      if (!done) chk("accept_timeout", 1'b0, 1'b1);
   endtask

   // Monitors: pop and compare on every downstream transfer.
   always @(negedge clk) begin
      if (vd8 === 1'b1 && s8 === 1'b0) begin
         shm <= {b8, shm[7:1]};
         if (q8.size() == 0) chk("u8_unexpected_bit", 1'b1, 1'b0);
         else begin
            logic [1:0] e;
            e = q8.pop_front();
            chk("u8_bit", b8, e[0]);
            chk("u8_last", l8, e[1]);
         end
      end
   end

   always @(negedge clk) begin
      if (vdm === 1'b1 && sm === 1'b0) begin
         if (qm.size() == 0) chk("um_unexpected_bit", 1'b1, 1'b0);
         else begin
            logic [1:0] e;
            e = qm.pop_front();
            chk("um_bit", bm, e[0]);
            chk("um_last", lm, e[1]);
         end
      end
   end

   always @(negedge clk) begin
      if (vd5 === 1'b1 && s5 === 1'b0) begin
         if (q5.size() == 0) chk("u5_unexpected_bit", 1'b1, 1'b0);
         else begin
            logic [1:0] e;
            e = q5.pop_front();
            chk("u5_bit", b5, e[0]);
            chk("u5_last", l5, e[1]);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      // 1. reset with valid_us and stall_ds high
      rst = 1'b1; v8 = 1'b1; s8 = 1'b1; d8 = 8'hFF;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("rst_valid", vd8, 1'b0);
         chk("rst_bit", b8, 1'b0);
         chk("rst_last", l8, 1'b0);
         chk("rst_stall_us", st8, 1'b0);
      end
      @(posedge clk); #1;
      rst = 1'b0; v8 = 1'b0; s8 = 1'b0;
      @(negedge clk);
      chk("post_rst_valid", vd8, 1'b0);
      chk("post_rst_stall_us", st8, 1'b0);
      @(posedge clk); #1;

      // 2. single word A5
      accept8(8'hA5, 8'b10100101);
      v8 = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         chk("t2_valid", vd8, 1'b1);
         chk("t2_stall_us", st8, (k < 8));
         chk("t2_last", l8, (k == 8));
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("t2_idle_after", vd8, 1'b0);
      @(posedge clk); #1;

      // 3. back-to-back A5, 3C
      accept8(8'hA5, 8'b10100101);
      chk_bubble = 1'b1;
      accept8(8'h3C, 8'b00111100);
      chk_bubble = 1'b0;
      v8 = 1'b0;
      for (int k = 9; k <= 16; k++) begin
         @(negedge clk);
         chk("t3_valid", vd8, 1'b1);
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("t3_idle_after", vd8, 1'b0);
      chk("t3_queue_drained", q8.size(), 0);
      @(posedge clk); #1;

      // 4. downstream stall on 4th bit (3 cycles) and on last bit (1 cycle)
      accept8(8'hA5, 8'b10100101);
      v8 = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         s8 = ((c >= 4 && c <= 6) || c == 11);
         @(negedge clk);
         chk("t4_valid", vd8, 1'b1);
         if (c >= 4 && c <= 6) begin
            chk("t4_hold_bit", b8, 1'b0);
            chk("t4_hold_last", l8, 1'b0);
            chk("t4_hold_stall_us", st8, 1'b1);
         end
         if (c == 11) begin
            chk("t4_last_stall_us", st8, 1'b1);
            chk("t4_last_stall_bit", b8, 1'b1);
            chk("t4_last_stall_last", l8, 1'b1);
         end
         if (c == 12) begin
            chk("t4_final_last", l8, 1'b1);
            chk("t4_final_stall_us", st8, 1'b0);
         end
         @(posedge clk); #1;
      end
      s8 = 1'b0;
      @(negedge clk);
      chk("t4_idle_after", vd8, 1'b0);
      chk("t4_deser_word", shm, 8'hA5);
      @(posedge clk); #1;

      // 5a. MSB first, C0
      vm = 1'b1; dm = 8'hC0;
      @(negedge clk);
      chk("t5m_accept", stm, 1'b0);
      @(posedge clk); #1;
      vm = 1'b0;
      push_seq(1, 8'b11000000, 8);
      for (int k = 0; k < 9; k++) begin
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("t5m_idle_after", vdm, 1'b0);
      chk("t5m_queue_drained", qm.size(), 0);
      @(posedge clk); #1;

      // 5b. W=5, 10011 LSB first
      v5 = 1'b1; d5 = 5'b10011;
      @(negedge clk);
      chk("t5w_accept", st5, 1'b0);
      @(posedge clk); #1;
      v5 = 1'b0;
      push_seq(2, 8'b00011001, 5);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         chk("t5w_valid", vd5, 1'b1);
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("t5w_idle_after", vd5, 1'b0);
      chk("t5w_queue_drained", q5.size(), 0);
      @(posedge clk); #1;

      // 6. reset mid-word after 3 bits, then FF
      accept8(8'hA5, 8'b10100101);
      v8 = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("t6_bits_before_rst", q8.size(), 5);
      q8.delete();
      @(negedge clk);
      chk("t6_rst_valid", vd8, 1'b0);
      chk("t6_rst_bit", b8, 1'b0);
      @(posedge clk); #1;
      accept8(8'hFF, 8'b11111111);
      v8 = 1'b0;
      for (int k = 0; k < 20 && q8.size() != 0; k++) begin
         @(posedge clk); #1;
      end
      chk("t6_queue_drained", q8.size(), 0);
      @(negedge clk);
      chk("t6_idle_after", vd8, 1'b0);
      @(posedge clk); #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vs_serializer.md
Name: vs_serializer

Overview:
Parallel-in, serial-out converter with valid/stall handshakes on both sides. It is the transmit-side counterpart of the `shifter` deserializer. It takes a W-bit word from an upstream valid/stall stage and emits it one bit per transfer. The default bit order is LSB first, which matches `shifter`: a `shifter` fed by this block with en = (valid_ds & ~stall_ds) reconstructs the original word. It sits at the boundary between word-wide pipeline stages and bit-serial links or consumers.

Parameters:
W, 8, word width in bits; legal range W >= 2.
MSB_FIRST, 0, bit order; 0 emits bit 0 first, 1 emits bit W-1 first.
CW, $clog2(W), localparam; bit-index counter width.

Ports:
clk  input  1  clock; all state changes on posedge.
rst  input  1  synchronous, active-high reset.
valid_us  input  1  upstream word valid.
data_us  input  W  upstream word; sampled only on an accept cycle.
stall_us  output  1  combinational; high means the upstream word is not accepted this cycle.
valid_ds  output  1  registered; a serial bit is present on bit_ds.
bit_ds  output  1  registered; the current serial bit.
last_ds  output  1  registered; high with the final bit of a word.
stall_ds  input  1  downstream cannot take the bit this cycle.

Behaviour:
- Clocking and reset: one clock (clk). Reset is synchronous and active-high (rst); it is sampled only at posedge clk.
- Reset state: state=IDLE, shift register=0, bit counter=0. Outputs: valid_ds=0, bit_ds=0, last_ds=0, stall_us=0.
- Reset mid-word: the partial word is dropped and no further bits are emitted. The first word after reset starts from its first bit.
- Bit transfer: occurs in a cycle where valid_ds=1 and stall_ds=0.
- Word accept: occurs in a cycle where valid_us=1 and stall_us=0.
- stall_us = (state==SHIFT) & ~(cnt==W-1 & ~stall_ds).
- State IDLE:
  - valid_ds=0, bit_ds=0, last_ds=0.
  - On accept: load data_us (bit-reversed if MSB_FIRST), set cnt=0, go to SHIFT.
  - stall_ds is ignored in IDLE.
- State SHIFT:
  - valid_ds=1, bit_ds=sreg[0], last_ds=(cnt==W-1).
  - On a transfer with cnt<W-1: shift sreg right by 1 (fill 0), cnt=cnt+1.
  - On a transfer with cnt==W-1 and an accept in the same cycle: load the new word, cnt=0, stay in SHIFT. This gives zero bubbles.
  - On a transfer with cnt==W-1 and no accept: go to IDLE and clear sreg.
  - While stall_ds=1: sreg, cnt, bit_ds, valid_ds and last_ds all hold; stall_us stays 1.
- Latency: a word accepted in cycle N has its first bit on bit_ds in cycle N+1. With no stalls the last bit appears in cycle N+W.
- Throughput: one bit per cycle. Back-to-back words are sent with no gap.
- data_us is not registered or inspected outside an accept cycle. valid_us=1 with stall_us=1 has no side effect.
- Counter arithmetic: cnt is CW bits and never exceeds W-1. No wrap occurs, because the last-bit compare is explicit (this matters for non-power-of-2 W).

Decomposition:
- Shared package vs_pkg holds:
  - typedef enum logic {IDLE, SHIFT} vs_ser_state_t.
  - The bit-transfer and word-accept conditions as documented functions, so they can be reused by other VS blocks.
- No sub-module. The library counter and ff_ar* blocks use asynchronous reset, so this block keeps its bit counter and registers inline with synchronous reset.

Test Plan:
1. Reset: rst=1 for 2 cycles with valid_us=1 and stall_ds=1 → valid_ds=0, bit_ds=0, last_ds=0, stall_us=0 throughout. Release rst → still idle, and stall_us=0.
2. W=8, one word 8'hA5 accepted at cycle N, stall_ds=0 → bit_ds is 1,0,1,0,0,1,0,1 in cycles N+1..N+8. last_ds=1 only at N+8. stall_us=1 at N+1..N+7 and 0 at N+8. valid_ds=0 at N+9.
3. Back-to-back words 8'hA5 then 8'h3C, valid_us held high → 16 contiguous valid_ds cycles with no bubble. The second word emits 0,0,1,1,1,1,0,0. last_ds=1 at N+8 and N+16.
4. Downstream stall: 8'hA5, stall_ds=1 for 3 cycles while the 4th bit (0) is shown, and again for 1 cycle on the last bit:
   - bit_ds, valid_ds and cnt hold steady during each stall.
   - stall_us stays 1 during the last-bit stall.
   - The word completes at N+12.
   - The shifter model downstream captures 8'hA5.
5. MSB_FIRST=1, word 8'hC0 → bit_ds is 1,1,0,0,0,0,0,0. A non-power-of-2 instance, W=5 with 5'b10011 and MSB_FIRST=0 → bit_ds is 1,1,0,0,1, and last_ds=1 on the 5th bit.
6. Reset mid-word: 8'hA5, assert rst after 3 bits → valid_ds=0 on the next cycle. Then send 8'hFF → exactly 8 ones are emitted, no residual bits from 8'hA5 appear, and last_ds=1 on the 8th.
